temporizador_bcd: RTL

TEMPORIZADOR_BCD -- requirements
Module: temporizador_bcd

---
 rtl/temporizador_pkg.sv | 20 ++
 rtl/bcd_digit_down.sv | 24 ++
 rtl/temporizador_bcd.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/temporizador_pkg.sv
// Shared types and BCD limits for the countdown timer.
package temporizador_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_DONE    = 2'd3
    } timer_state_t;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam logic [3:0] BCD_TENS_MAX  = 4'd5;

    function automatic logic bcd_time_is_zero(input logic [3:0] m,
                                              input logic [3:0] t,
                                              input logic [3:0] o);
        return (m == 4'd0) && (t == 4'd0) && (o == 4'd0);
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// Single BCD digit decrementer: wraps to a given value and borrows out on 0.
module bcd_digit_down (
    input  logic [3:0] digit,
    input  logic [3:0] wrap,
    input  logic       borrow_in,
    output logic [3:0] q,
    output logic       borrow_out
);

    // Decrement only when asked; a zero digit wraps and passes the borrow up.
    always_comb begin
        q          = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                q          = wrap;
                borrow_out = 1'b1;
            end else begin
                q = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/temporizador_bcd.sv
// Keypad-loaded m:ss BCD countdown timer with pause, completion pulse and alarm.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | keypad entry shifts digits in; start begins a nonzero count
// ST_RUNNING | each tick removes one second; stop pauses
// ST_PAUSED  | digits frozen; start resumes
// ST_DONE    | reached 0:00, alarm held until clear or reset
module temporizador_bcd
    import temporizador_pkg::*;
#(
    parameter int unsigned MAX_MINS = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] din,
    input  logic       din_valid,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] mins,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    localparam logic [3:0] MINS_LIMIT = 4'(MAX_MINS);

    timer_state_t state_q, state_d;
    logic [3:0]   mins_d, tens_d, ones_d;
    logic         done_d;

    logic [3:0]   dec_mins, dec_tens, dec_ones;
    logic         ones_borrow, tens_borrow, mins_borrow;
    logic         time_nonzero, shift_ok;

    bcd_digit_down u_ones (
        .digit      (sec_ones),
        .wrap       (BCD_DIGIT_MAX),
        .borrow_in  (1'b1),
        .q          (dec_ones),
        .borrow_out (ones_borrow)
    );

    bcd_digit_down u_tens (
        .digit      (sec_tens),
        .wrap       (BCD_TENS_MAX),
        .borrow_in  (ones_borrow),
        .q          (dec_tens),
        .borrow_out (tens_borrow)
    );

    // A borrow out of the minutes digit would mean counting below 0:00.
    bcd_digit_down u_mins (
        .digit      (mins),
        .wrap       (BCD_DIGIT_MAX),
        .borrow_in  (tens_borrow),
        .q          (dec_mins),
        .borrow_out (mins_borrow)
    );

    assign time_nonzero = !bcd_time_is_zero(mins, sec_tens, sec_ones);

    // The shifted-in value must stay a legal m:ss time or the key is dropped.
    assign shift_ok = (din <= BCD_DIGIT_MAX) &&
                      (sec_ones <= BCD_TENS_MAX) &&
                      (sec_tens <= MINS_LIMIT);

    // Next state and next digits, priority clear > stop > start > tick > din_valid.
    always_comb begin
        state_d = state_q;
        mins_d  = mins;
        tens_d  = sec_tens;
        ones_d  = sec_ones;
        done_d  = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            mins_d  = 4'd0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && time_nonzero) begin
                        state_d = ST_RUNNING;
                    end else if (din_valid && shift_ok) begin
                        mins_d = sec_tens;
                        tens_d = sec_ones;
                        ones_d = din;
                    end
                end
                ST_RUNNING: begin
                    if (stop) begin
                        state_d = ST_PAUSED;
                    end else if (tick && !mins_borrow) begin
                        mins_d = dec_mins;
                        tens_d = dec_tens;
                        ones_d = dec_ones;
                        if (bcd_time_is_zero(dec_mins, dec_tens, dec_ones)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (start) begin
                        state_d = ST_RUNNING;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, digits and status flags all come straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mins     <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            running  <= 1'b0;
            done     <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mins     <= mins_d;
            sec_tens <= tens_d;
            sec_ones <= ones_d;
            running  <= (state_d == ST_RUNNING);
            done     <= done_d;
            alarm    <= (state_d == ST_DONE);
        end
    end

endmodule
